// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/LS memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_t;

  // Owner value doubles as the bit index into the req/grant vectors.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, LS and shared memory port handshakes around the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
  parameter int DATA_W  = mem_arb_pkg::DATA_W,
  parameter int INSTR_W = mem_arb_pkg::INSTR_W
);
  logic               if_req_valid;
  logic               if_req_ready;
  logic [ADDR_W-1:0]  if_addr;
  logic               if_rsp_valid;
  logic [INSTR_W-1:0] if_rsp_data;

  logic               ls_req_valid;
  logic               ls_req_ready;
  logic               ls_we;
  logic [ADDR_W-1:0]  ls_addr;
  logic [DATA_W-1:0]  ls_wdata;
  logic               ls_rsp_valid;
  logic [DATA_W-1:0]  ls_rsp_data;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_rsp_valid;
  logic [DATA_W-1:0]  mem_rsp_data;

  // Arbiter view.
  modport master (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_we, ls_addr, ls_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_req_valid, mem_we, mem_addr, mem_wdata
  );

  // Core + memory view.
  modport slave (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_we, ls_addr, ls_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input arbiter, bit 0 = IF, bit 1 = LS. Round robin by default;
// ARB_LS_PRIORITY_EN switches to fixed LS priority.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

`ifdef ARB_LS_PRIORITY_EN
  logic unused_rr;
  assign unused_rr = update ^ clk ^ rst_n;

  always_comb begin
    grant = req;
    if (req[OWN_LS]) grant = 2'b10;
  end
`else
  owner_t last_grant;

  // On a tie the side that did not win last time goes next.
  always_comb begin
    grant = req;
    if (&req) grant = (last_grant == OWN_LS) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= OWN_LS;
    else if (update) last_grant <= grant[OWN_LS] ? OWN_LS : OWN_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between IF and LS, one transaction in flight.
// Tie policy set by ARB_LS_PRIORITY_EN inside rr_arb2 (round robin when undefined).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
  parameter int DATA_W  = mem_arb_pkg::DATA_W,
  parameter int INSTR_W = mem_arb_pkg::INSTR_W
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.master bus
);

  arb_state_t         state;
  owner_t             owner;
  logic [1:0]         req, grant;
  logic               accept;
  logic               mem_req_valid_q, mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               if_rsp_valid_q, ls_rsp_valid_q;
  logic [INSTR_W-1:0] if_rsp_data_q;
  logic [DATA_W-1:0]  ls_rsp_data_q;

  // Requests are only visible to the arbiter while idle and out of reset,
  // so both readies read 0 during reset and while busy.
  assign req = (rst_n && state == ST_IDLE) ? {bus.ls_req_valid, bus.if_req_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (accept),
    .grant  (grant)
  );

  assign accept           = |grant;
  assign bus.if_req_ready = grant[OWN_IF];
  assign bus.ls_req_ready = grant[OWN_LS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      owner           <= OWN_IF;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      if_rsp_valid_q  <= 1'b0;
      ls_rsp_valid_q  <= 1'b0;
      if_rsp_data_q   <= '0;
      ls_rsp_data_q   <= '0;
    end else begin
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          owner           <= grant[OWN_LS] ? OWN_LS : OWN_IF;
          mem_we_q        <= grant[OWN_LS] & bus.ls_we;
          mem_addr_q      <= grant[OWN_LS] ? bus.ls_addr : bus.if_addr;
          mem_wdata_q     <= grant[OWN_LS] ? bus.ls_wdata : '0;
          mem_req_valid_q <= 1'b1;
          state           <= ST_REQ;
        end
        ST_REQ: if (bus.mem_req_ready) begin
          mem_req_valid_q <= 1'b0;
          state           <= ST_RSP;
        end
        ST_RSP: if (bus.mem_rsp_valid) begin
          // IF word picks its little-endian 32-bit lane by the latched addr[2].
          if (owner == OWN_IF) begin
            if_rsp_data_q  <= mem_addr_q[2] ? bus.mem_rsp_data[DATA_W-1 -: INSTR_W]
                                            : bus.mem_rsp_data[INSTR_W-1:0];
            if_rsp_valid_q <= 1'b1;
          end else begin
            ls_rsp_data_q  <= bus.mem_rsp_data;
            ls_rsp_valid_q <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.if_rsp_valid  = if_rsp_valid_q;
  assign bus.if_rsp_data   = if_rsp_data_q;
  assign bus.ls_rsp_valid  = ls_rsp_valid_q;
  assign bus.ls_rsp_data   = ls_rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model that plays core and memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: memory contents, one open transaction, expected response registers.
  logic [63:0] mem_m [16];
  int          m_busy;      // 0 free, 1 request offered to memory, 2 waiting for data
  int          m_last;      // 0 IF, 1 LS
  int          t_own;
  logic        t_we;
  logic [63:0] t_addr, t_wdata;
  logic        e_if_v, e_ls_v;
  logic [31:0] e_if_d;
  logic [63:0] e_ls_d;
  int          if_pulses = 0;
  int          ls_pulses = 0;
  int          grants_q[$];

  function automatic int pick(input logic iv, input logic lv);
    if (iv && lv) begin
`ifdef ARB_LS_PRIORITY_EN
      return 1;
`else
      return (m_last == 1) ? 0 : 1;
`endif
    end
    if (iv) return 0;
    if (lv) return 1;
    return -1;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = 1;
    e_if_v = 1'b0; e_ls_v = 1'b0; e_if_d = '0; e_ls_d = '0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic iv, input logic [63:0] ia, input logic lv, input logic lwe,
                      input logic [63:0] la, input logic [63:0] lw,
                      input logic mrdy, input logic mrv);
    logic [63:0] rd;
    int w;
    chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(m_busy == 1));
    if (m_busy == 1) begin
      chk("mem_addr", bus.mem_addr, t_addr);
      chk("mem_we", 64'(bus.mem_we), 64'(t_we));
      if (t_we) chk("mem_wdata", bus.mem_wdata, t_wdata);
    end
    chk("if_rsp_valid", 64'(bus.if_rsp_valid), 64'(e_if_v));
    chk("ls_rsp_valid", 64'(bus.ls_rsp_valid), 64'(e_ls_v));
    chk("if_rsp_data", 64'(bus.if_rsp_data), 64'(e_if_d));
    chk("ls_rsp_data", bus.ls_rsp_data, e_ls_d);
    if (bus.if_rsp_valid) if_pulses++;
    if (bus.ls_rsp_valid) ls_pulses++;

    rd = (m_busy == 2 && !t_we) ? mem_m[t_addr[6:3]] : rnd64();
    bus.if_req_valid  = iv;  bus.if_addr = ia;
    bus.ls_req_valid  = lv;  bus.ls_we = lwe; bus.ls_addr = la; bus.ls_wdata = lw;
    bus.mem_req_ready = mrdy;
    bus.mem_rsp_valid = mrv; bus.mem_rsp_data = rd;
    #1;
    w = (m_busy == 0) ? pick(iv, lv) : -1;
    chk("if_req_ready", 64'(bus.if_req_ready), 64'(w == 0));
    chk("ls_req_ready", 64'(bus.ls_req_ready), 64'(w == 1));
    if (bus.if_req_ready) grants_q.push_back(0);
    if (bus.ls_req_ready) grants_q.push_back(1);

    e_if_v = 1'b0; e_ls_v = 1'b0;
    case (m_busy)
      0: if (w >= 0) begin
        t_own = w; t_we = (w == 1) && lwe;
        t_addr = (w == 1) ? la : ia; t_wdata = lw;
        m_last = w; m_busy = 1;
      end
      1: if (mrdy) m_busy = 2;
      default: if (mrv) begin
        if (t_own == 0) begin
          e_if_v = 1'b1;
          e_if_d = t_addr[2] ? rd[63:32] : rd[31:0];
        end else begin
          e_ls_v = 1'b1;
          e_ls_d = rd;
          if (t_we) mem_m[t_addr[6:3]] = t_wdata;
        end
        m_busy = 0;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic idle_cycle(input logic mrdy, input logic mrv);
    step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, mrdy, mrv);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {58'h0, bus.mem_req_valid, bus.mem_we, bus.if_req_ready,
                         bus.ls_req_ready, bus.if_rsp_valid, bus.ls_rsp_valid}, 64'h0);
    chk({tag, "_addr"}, bus.mem_addr, 64'h0);
    chk({tag, "_wdata"}, bus.mem_wdata, 64'h0);
    chk({tag, "_ifd"}, 64'(bus.if_rsp_data), 64'h0);
    chk({tag, "_lsd"}, bus.ls_rsp_data, 64'h0);
  endtask

  initial begin
    int p_if, p_ls;
    for (int i = 0; i < 16; i++) mem_m[i] = rnd64();
    bus.if_req_valid = 1'b0; bus.if_addr = '0;
    bus.ls_req_valid = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    model_reset();
    @(negedge clk);
    bus.if_req_valid = 1'b1; bus.ls_req_valid = 1'b1;
    #1;
    check_all_zero("por");
    bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Tie on every cycle: grant order follows the tie policy.
    grants_q.delete();
    for (int c = 0; c < 40 && grants_q.size() < 4; c++)
      step(1'b1, rnd64(), 1'b1, 1'b0, rnd64(), 64'h0, 1'b1, 1'b1);
    chk("tie_count", 64'(grants_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < grants_q.size(); k++) begin
`ifdef ARB_LS_PRIORITY_EN
      chk($sformatf("tie_grant%0d", k), 64'(grants_q[k]), 64'd1);
`else
      chk($sformatf("tie_grant%0d", k), 64'(grants_q[k]), 64'(k % 2));
`endif
    end
    for (int c = 0; c < 10 && m_busy != 0; c++) idle_cycle(1'b1, 1'b1);
    idle_cycle(1'b0, 1'b0);

    // IF fetch from upper lane, minimum latency.
    mem_m[0] = 64'hDEADBEEF_00000013;
    p_if = if_pulses;
    step(1'b1, 64'h4, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    idle_cycle(1'b1, 1'b0);
    idle_cycle(1'b0, 1'b1);
    chk("if_pulse_pending", 64'(if_pulses - p_if), 64'd0);
    idle_cycle(1'b0, 1'b0);
    chk("if_pulse_at_n3", 64'(if_pulses - p_if), 64'd1);
    chk("if_word", 64'(bus.if_rsp_data), 64'hDEADBEEF);

    // Store 42 to 0x10, load it back; the load is accepted in the ack cycle.
    p_ls = ls_pulses;
    step(1'b0, 64'h0, 1'b1, 1'b1, 64'h10, 64'd42, 1'b0, 1'b0);
    idle_cycle(1'b1, 1'b0);
    idle_cycle(1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0);
    idle_cycle(1'b1, 1'b0);
    idle_cycle(1'b0, 1'b1);
    idle_cycle(1'b0, 1'b0);
    chk("ls_pulses", 64'(ls_pulses - p_ls), 64'd2);
    chk("ls_load42", bus.ls_rsp_data, 64'd42);

    // Memory back-pressure and slow response.
    p_if = if_pulses;
    step(1'b1, 64'h1238, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b1, rnd64(), 1'b1, 1'b1, rnd64(), rnd64(), 1'b0, 1'b0);
    idle_cycle(1'b1, 1'b0);
    for (int c = 0; c < 7; c++) step(1'b1, rnd64(), 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    idle_cycle(1'b0, 1'b1);
    idle_cycle(1'b0, 1'b0);
    chk("slow_pulses", 64'(if_pulses - p_if), 64'd1);

    // Spurious memory responses while idle.
    p_if = if_pulses; p_ls = ls_pulses;
    for (int c = 0; c < 6; c++) idle_cycle(1'b1, 1'b1);
    chk("spurious_pulses", 64'(if_pulses - p_if + ls_pulses - p_ls), 64'd0);

    // Reset while a request is on the memory port.
    step(1'b0, 64'h0, 1'b1, 1'b1, 64'h28, rnd64(), 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 64'h30, 64'h0, 1'b0, 1'b0);
    chk("pre_rst_req", 64'(bus.mem_req_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    p_ls = ls_pulses;
    for (int c = 0; c < 4; c++) idle_cycle(1'b1, 1'b1);
    chk("post_rst_pulses", 64'(ls_pulses - p_ls), 64'd0);

    // Random traffic.
    for (int c = 0; c < 1500; c++)
      step($urandom_range(0, 9) < 6, rnd64(), $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
           rnd64(), rnd64(), $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
